// File: rtl/cache_ctrl.sv
// cache_ctrl: single-outstanding CPU load/store front end for a lookup/update
// cache with write-through to memory. Read hits are served from the cache, read
// misses are fetched from memory and filled, writes go to memory first and are
// then written into the cache. Read hit/miss statistics are kept in wrapping
// counters.
module cache_ctrl #(
  parameter int XLEN        = 32,
  parameter int BYTE_OFFSET = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // CPU request/response
  input  logic                 cpu_req_valid,
  output logic                 cpu_req_ready,
  input  logic [XLEN-1:0]      cpu_req_addr,
  input  logic                 cpu_req_we,
  input  logic [XLEN-1:0]      cpu_req_wdata,
  output logic                 cpu_resp_valid,
  output logic [XLEN-1:0]      cpu_resp_data,
  // cache lookup / update
  output logic [XLEN-1:0]      cache_addr,
  input  logic                 cache_hit,
  input  logic [XLEN-1:0]      cache_data,
  output logic                 cache_update,
  output logic [XLEN-1:0]      cache_update_addr,
  output logic [XLEN-1:0]      cache_update_data,
  // memory request/response
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [XLEN-1:0]      mem_req_addr,
  output logic                 mem_req_we,
  output logic [XLEN-1:0]      mem_req_wdata,
  input  logic                 mem_resp_valid,
  input  logic [XLEN-1:0]      mem_resp_data,
  // statistics
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MEM_REQ  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_FILL     = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [XLEN-1:0]       r_addr;
  logic                  r_we;
  logic [XLEN-1:0]       r_wdata;
  logic [XLEN-1:0]       r_fill_data;
  logic [XLEN-1:0]       r_resp_data;
  logic                  r_resp_valid;
  logic                  r_update;
  logic                  r_mem_valid;
  logic [CNT_WIDTH-1:0]  r_hit_count;
  logic [CNT_WIDTH-1:0]  r_miss_count;

  logic                  w_accept;
  logic [XLEN-1:0]       w_aligned;
  logic                  w_fill_go;
  logic                  w_resp_valid_nxt;
  logic [XLEN-1:0]       w_resp_data_nxt;
  logic [XLEN-1:0]       w_fill_data_nxt;
  logic                  w_mem_valid_nxt;
  logic                  w_hit_inc;
  logic                  w_miss_inc;

  assign w_accept  = cpu_req_valid && (r_state == S_IDLE);
  assign w_aligned = {cpu_req_addr[XLEN-1:BYTE_OFFSET], {BYTE_OFFSET{1'b0}}};

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next = cpu_req_we ? S_MEM_REQ : S_LOOKUP;
      S_LOOKUP:   w_next = cache_hit ? S_IDLE : S_MEM_REQ;
      S_MEM_REQ:  if (mem_req_ready) w_next = r_we ? S_FILL : S_MEM_WAIT;
      S_MEM_WAIT: if (mem_resp_valid) w_next = S_FILL;
      S_FILL:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, decided per state.
  always_comb begin
    w_fill_go        = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_resp_data_nxt  = r_resp_data;
    w_fill_data_nxt  = r_fill_data;
    w_hit_inc        = 1'b0;
    w_miss_inc       = 1'b0;
    case (r_state)
      S_LOOKUP: begin
        if (cache_hit) begin
          w_resp_valid_nxt = 1'b1;
          w_resp_data_nxt  = cache_data;
          w_hit_inc        = 1'b1;
        end else begin
          w_miss_inc = 1'b1;
        end
      end
      S_MEM_REQ: begin
        // A write completes as soon as memory takes it; the fill carries wdata.
        if (mem_req_ready && r_we) begin
          w_fill_go       = 1'b1;
          w_fill_data_nxt = r_wdata;
        end
      end
      S_MEM_WAIT: begin
        if (mem_resp_valid) begin
          w_fill_go       = 1'b1;
          w_fill_data_nxt = mem_resp_data;
        end
      end
      default: ;
    endcase
    if (w_fill_go) begin
      w_resp_valid_nxt = 1'b1;
      w_resp_data_nxt  = w_fill_data_nxt;
    end
    w_mem_valid_nxt = (w_next == S_MEM_REQ);
  end

  // Request latch: address (word aligned), direction and write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_addr  <= w_aligned;
      r_we    <= cpu_req_we;
      r_wdata <= cpu_req_wdata;
    end
  end

  // Registered response, cache update strobe, fill data and memory request valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_fill_data  <= '0;
      r_update     <= 1'b0;
      r_mem_valid  <= 1'b0;
    end else begin
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_fill_data  <= w_fill_data_nxt;
      r_update     <= w_fill_go;
      r_mem_valid  <= w_mem_valid_nxt;
    end
  end

  // Read hit/miss statistics, wrapping at 2^CNT_WIDTH; writes are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_inc)  r_hit_count  <= r_hit_count + CNT_WIDTH'(1);
      if (w_miss_inc) r_miss_count <= r_miss_count + CNT_WIDTH'(1);
    end
  end

  assign cpu_req_ready     = (r_state == S_IDLE);
  assign cpu_resp_valid    = r_resp_valid;
  assign cpu_resp_data     = r_resp_data;
  assign cache_addr        = r_addr;
  assign cache_update      = r_update;
  assign cache_update_addr = r_addr;
  assign cache_update_data = r_fill_data;
  assign mem_req_valid     = r_mem_valid;
  assign mem_req_addr      = r_addr;
  assign mem_req_we        = r_we;
  assign mem_req_wdata     = r_wdata;
  assign hit_count         = r_hit_count;
  assign miss_count        = r_miss_count;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed plus randomized requests against a word-level
// reference model of a write-through cache (model memory + model cache
// contents + expected hit/miss counts and latencies).
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic [31:0] cpu_req_addr = '0;
  logic        cpu_req_we = 1'b0;
  logic [31:0] cpu_req_wdata = '0;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic [31:0] cache_addr;
  logic        cache_hit;
  logic [31:0] cache_data;
  logic        cache_update;
  logic [31:0] cache_update_addr;
  logic [31:0] cache_update_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  // second instance with 2-bit counters, fed the same inputs
  logic        u2_ready, u2_resp_valid, u2_update, u2_mem_valid, u2_mem_we;
  logic [31:0] u2_resp_data, u2_cache_addr, u2_upd_addr, u2_upd_data, u2_mem_addr, u2_mem_wdata;
  logic [1:0]  u2_hit, u2_miss;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .cache_addr(cache_addr), .cache_hit(cache_hit), .cache_data(cache_data),
    .cache_update(cache_update), .cache_update_addr(cache_update_addr),
    .cache_update_data(cache_update_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_ctrl #(.XLEN(32), .BYTE_OFFSET(2), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(u2_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(u2_resp_valid), .cpu_resp_data(u2_resp_data),
    .cache_addr(u2_cache_addr), .cache_hit(cache_hit), .cache_data(cache_data),
    .cache_update(u2_update), .cache_update_addr(u2_upd_addr),
    .cache_update_data(u2_upd_data),
    .mem_req_valid(u2_mem_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(u2_mem_addr), .mem_req_we(u2_mem_we), .mem_req_wdata(u2_mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(u2_hit), .miss_count(u2_miss)
  );

  // environment: 256-word cache array and memory array (addresses below 0x400)
  logic        cv [256];
  logic [31:0] cd [256];
  logic [31:0] em [256];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;

  assign cache_hit  = (cache_addr[31:10] == 22'd0) && cv[cache_addr[9:2]];
  assign cache_data = cd[cache_addr[9:2]];

  always @(posedge clk) begin
    if (ld_en) begin
      em[ld_idx] <= ld_data;
      cv[ld_idx] <= 1'b0;
      cd[ld_idx] <= 32'd0;
    end else begin
      if (cache_update) begin
        cv[cache_update_addr[9:2]] <= 1'b1;
        cd[cache_update_addr[9:2]] <= cache_update_data;
      end
      if (mem_req_valid && mem_req_ready && mem_req_we)
        em[mem_req_addr[9:2]] <= mem_req_wdata;
    end
  end

  // reference model state
  logic [31:0] mm  [256];
  logic        mcv [256];
  logic [31:0] mcd [256];
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int w, input int d);
    logic [7:0]  idx;
    logic [31:0] al, exp_data;
    logic        exp_hit, rdy;
    int          exp_c, c, rdy_c, resp_c, mem_seen, upd_seen;
    idx = addr[9:2];
    al  = {addr[31:2], 2'b00};
    exp_hit = 1'b0;
    if (we) begin
      mm[idx] = wd; mcv[idx] = 1'b1; mcd[idx] = wd;
      exp_data = wd; exp_c = 1 + w;
    end else if (mcv[idx]) begin
      exp_hit = 1'b1; exp_data = mcd[idx]; exp_hits++; exp_c = 1;
    end else begin
      exp_data = mm[idx]; mcv[idx] = 1'b1; mcd[idx] = mm[idx];
      exp_misses++; exp_c = 2 + w + d;
    end
    rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (cpu_req_ready === 1'b1) begin rdy = 1'b1; break; end
      @(negedge clk);
    end
    chk("req_ready", 32'(rdy), 32'd1);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = addr;
    cpu_req_we    = we;
    cpu_req_wdata = we ? wd : $urandom;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    c = 0; rdy_c = -1; resp_c = -1; mem_seen = 0; upd_seen = 0;
    while (c < 64) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (mem_req_valid) begin
        chk("mem_req_addr", mem_req_addr, al);
        chk("mem_req_we", 32'(mem_req_we), 32'(we));
        if (we) chk("mem_req_wdata", mem_req_wdata, wd);
        if (mem_seen == w) begin mem_req_ready = 1'b1; rdy_c = c; end
        mem_seen++;
      end
      if (rdy_c >= 0 && !we && c == rdy_c + d) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = em[idx];
      end
      if (cache_update) begin
        upd_seen++;
        chk("cache_update_addr", cache_update_addr, al);
        chk("cache_update_data", cache_update_data, exp_data);
      end
      if (cpu_resp_valid) begin resp_c = c; break; end
      @(negedge clk);
      c++;
    end
    chk("resp_latency", 32'(resp_c), 32'(exp_c));
    chk("resp_data", cpu_resp_data, exp_data);
    chk("cache_update_pulses", 32'(upd_seen), exp_hit ? 32'd0 : 32'd1);
    if (exp_hit) chk("mem_req_on_hit", 32'(mem_seen), 32'd0);
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);
    chk("hit_count_w2", 32'(u2_hit), 32'(exp_hits[1:0]));
  endtask

  initial begin
    logic        seen, bad;
    logic [31:0] v;
    // preload memory, clear cache, all under reset
    for (int i = 0; i < 256; i++) begin
      v = (i == 8'h40) ? 32'hDEADBEEF : $urandom;
      ld_en = 1'b1; ld_idx = 8'(i); ld_data = v;
      mm[i] = v; mcv[i] = 1'b0; mcd[i] = 32'd0;
      @(negedge clk);
    end
    ld_en = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    chk("rst_cache_update", 32'(cache_update), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(cpu_req_ready), 32'd1);

    // cold read miss, then hits on the same word
    do_txn(1'b0, 32'h100, 32'd0, 0, 1);
    do_txn(1'b0, 32'h100, 32'd0, 0, 1);
    do_txn(1'b0, 32'h102, 32'd0, 0, 1);

    // write with memory stalling three cycles, then read it back
    do_txn(1'b1, 32'h200, 32'h12345678, 3, 1);
    do_txn(1'b0, 32'h200, 32'd0, 0, 1);

    // slow memory response, then a stray response while idle
    do_txn(1'b0, 32'h300, 32'd0, 1, 5);
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBADC0DE0;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (cpu_resp_valid || cache_update || !cpu_req_ready) bad = 1'b1;
    end
    chk("stray_resp_ignored", 32'(bad), 32'd0);

    // reset while waiting for memory data
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h304; cpu_req_we = 1'b0; cpu_req_wdata = 32'd0;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (mem_req_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("mid_mem_req_seen", 32'(seen), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    chk("arst_cache_update", 32'(cache_update), 32'd0);
    chk("arst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("arst_mem_req_addr", mem_req_addr, 32'd0);
    chk("arst_miss_count", miss_count, 32'd0);
    chk("arst_ready", 32'(cpu_req_ready), 32'd1);
    exp_hits = 0; exp_misses = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hFEEDF00D;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (cpu_resp_valid || cache_update) bad = 1'b1;
    end
    chk("late_resp_ignored", 32'(bad), 32'd0);
    do_txn(1'b0, 32'h304, 32'd0, 0, 2);

    // four hits wrap the 2-bit counter
    for (int k = 0; k < 4; k++) do_txn(1'b0, 32'h100, 32'd0, 0, 1);
    chk("hit_wrap", 32'(u2_hit), 32'd0);

    // randomized traffic over a small address window
    for (int n = 0; n < 40; n++) begin
      do_txn(($urandom % 3) == 0, ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
             $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
